// File: rtl/posi_ctrl.sv
// Per-CTU sequencer: pre-transfer, intra prediction, post-transfer, then completion.
// Holds one start request while busy; any further request is dropped and flagged.
`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 8
`endif

module posi_ctrl #(
  parameter logic        MODE_PRE = 1'b0,
  parameter logic        MODE_POS = 1'b1,
  parameter int unsigned CNT_WD   = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start_i,
  input  logic [`PIC_X_WIDTH-1:0] ctu_x_i,
  output logic                    tra_start_o,
  output logic                    tra_mode_o,
  output logic [`PIC_X_WIDTH-1:0] tra_ctu_x_o,
  input  logic                    tra_done_i,
  output logic                    prd_start_o,
  input  logic                    prd_done_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [CNT_WD-1:0]       cyc_cnt_o,
  output logic                    ovf_o
);

  typedef enum logic [2:0] {
    StIdle,
    StPreIss,
    StPreWt,
    StPrdIss,
    StPrdWt,
    StPosIss,
    StPosWt,
    StFin
  } state_e;

  state_e                  r_state;
  state_e                  w_state_d;
  logic                    r_pnd_vld;
  logic [`PIC_X_WIDTH-1:0] r_pnd_x;
  logic [CNT_WD-1:0]       r_cnt;
  logic [CNT_WD-1:0]       w_cnt_inc;
  logic                    w_cnt_run;
  logic                    w_enter_pre;
  logic                    w_busy_req;
  logic                    w_pnd_wr;
  logic                    w_drop;
  logic [`PIC_X_WIDTH-1:0] w_next_x;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:   if (start_i) w_state_d = StPreIss;
      StPreIss: w_state_d = StPreWt;
      StPreWt:  if (tra_done_i) w_state_d = StPrdIss;
      StPrdIss: w_state_d = StPrdWt;
      StPrdWt:  if (prd_done_i) w_state_d = StPosIss;
      StPosIss: w_state_d = StPosWt;
      StPosWt:  if (tra_done_i) w_state_d = StFin;
      StFin:    w_state_d = (r_pnd_vld || start_i) ? StPreIss : StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // A start in FIN with an empty pending slot bypasses the slot and is consumed directly.
  assign w_busy_req  = start_i && (r_state != StIdle) && !((r_state == StFin) && !r_pnd_vld);
  assign w_pnd_wr    = w_busy_req && !r_pnd_vld;
  assign w_drop      = w_busy_req && r_pnd_vld;
  assign w_enter_pre = (w_state_d == StPreIss);
  assign w_next_x    = ((r_state == StFin) && r_pnd_vld) ? r_pnd_x : ctu_x_i;
  assign w_cnt_run   = (r_state != StIdle) && (r_state != StFin);
  assign w_cnt_inc   = (r_cnt == {CNT_WD{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= StIdle;
      r_pnd_vld   <= 1'b0;
      r_pnd_x     <= '0;
      r_cnt       <= '0;
      tra_start_o <= 1'b0;
      tra_mode_o  <= MODE_PRE;
      tra_ctu_x_o <= '0;
      prd_start_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      cyc_cnt_o   <= '0;
      ovf_o       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      tra_start_o <= (w_state_d == StPreIss) || (w_state_d == StPosIss);
      tra_mode_o  <= ((w_state_d == StPosIss) || (w_state_d == StPosWt)) ? MODE_POS : MODE_PRE;
      prd_start_o <= (w_state_d == StPrdIss);
      busy_o      <= (w_state_d != StIdle);
      done_o      <= (w_state_d == StFin);
      if (w_drop) ovf_o <= 1'b1;

      if (w_pnd_wr) begin
        r_pnd_vld <= 1'b1;
        r_pnd_x   <= ctu_x_i;
      end else if (r_state == StFin) begin
        r_pnd_vld <= 1'b0;
      end

      if (w_enter_pre) begin
        tra_ctu_x_o <= w_next_x;
        r_cnt       <= '0;
      end else if (w_cnt_run) begin
        r_cnt <= w_cnt_inc;
      end

      // The final counted cycle is the one that leaves POS_WT, hence the incremented value.
      if (w_state_d == StFin) cyc_cnt_o <= w_cnt_inc;
    end
  end

endmodule

// File: tb/tb_posi_ctrl.sv
// Directed bench for posi_ctrl: single CTU, back-to-back with overflow, reset abort,
// and counter saturation on a narrow-counter second instance sharing the same stimulus.
`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 8
`endif

module tb_posi_ctrl;
  localparam int XW = `PIC_X_WIDTH;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start_i;
  logic [XW-1:0] ctu_x_i;
  logic          tra_done_i;
  logic          prd_done_i;

  logic          tra_start_o, tra_mode_o, prd_start_o, busy_o, done_o, ovf_o;
  logic [XW-1:0] tra_ctu_x_o;
  logic [15:0]   cyc_cnt_o;

  logic          s_tra_start, s_tra_mode, s_prd_start, s_busy, s_done, s_ovf;
  logic [XW-1:0] s_tra_ctu_x;
  logic [3:0]    s_cyc_cnt;

  int checks = 0;
  int errors = 0;
  int n_tra  = 0;
  int n_prd  = 0;
  int n_done = 0;
  int b_tra, b_prd, b_done;

  always #5 clk = ~clk;

  posi_ctrl #(.MODE_PRE(1'b0), .MODE_POS(1'b1), .CNT_WD(16)) u_dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .ctu_x_i(ctu_x_i),
    .tra_start_o(tra_start_o), .tra_mode_o(tra_mode_o), .tra_ctu_x_o(tra_ctu_x_o),
    .tra_done_i(tra_done_i), .prd_start_o(prd_start_o), .prd_done_i(prd_done_i),
    .busy_o(busy_o), .done_o(done_o), .cyc_cnt_o(cyc_cnt_o), .ovf_o(ovf_o)
  );

  posi_ctrl #(.MODE_PRE(1'b0), .MODE_POS(1'b1), .CNT_WD(4)) u_sat (
    .clk(clk), .rstn(rstn), .start_i(start_i), .ctu_x_i(ctu_x_i),
    .tra_start_o(s_tra_start), .tra_mode_o(s_tra_mode), .tra_ctu_x_o(s_tra_ctu_x),
    .tra_done_i(tra_done_i), .prd_start_o(s_prd_start), .prd_done_i(prd_done_i),
    .busy_o(s_busy), .done_o(s_done), .cyc_cnt_o(s_cyc_cnt), .ovf_o(s_ovf)
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (tra_start_o) n_tra++;
    if (prd_start_o) n_prd++;
    if (done_o) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_tra  = n_tra;
    b_prd  = n_prd;
    b_done = n_done;
  endtask

  initial begin
    rstn = 1'b0; start_i = 1'b0; ctu_x_i = '0; tra_done_i = 1'b0; prd_done_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tra_start", 32'(tra_start_o), 0);
    check("rst_prd_start", 32'(prd_start_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_ovf", 32'(ovf_o), 0);
    check("rst_mode", 32'(tra_mode_o), 0);
    check("rst_ctu_x", 32'(tra_ctu_x_o), 0);
    check("rst_cyc", 32'(cyc_cnt_o), 0);
    rstn = 1'b1;
    tick();
    check("idle_busy", 32'(busy_o), 0);

    // Single CTU x=5: 20/30/20 cycle phases, spurious dones injected mid-wait.
    snap();
    start_i = 1'b1; ctu_x_i = 8'd5;
    tick();
    start_i = 1'b0; ctu_x_i = '0;
    check("c1_pre_start", 32'(tra_start_o), 1);
    check("c1_pre_mode", 32'(tra_mode_o), 0);
    check("c1_ctu_x", 32'(tra_ctu_x_o), 5);
    check("c1_busy", 32'(busy_o), 1);
    for (int i = 1; i <= 20; i++) begin
      if (i == 8) prd_done_i = 1'b1;
      tick();
      prd_done_i = 1'b0;
    end
    check("c1_spur_prd_in_pre", 32'(prd_start_o), 0);
    tra_done_i = 1'b1;
    tick();
    tra_done_i = 1'b0;
    check("c1_prd_start", 32'(prd_start_o), 1);
    check("c1_prd_ctu_x", 32'(tra_ctu_x_o), 5);
    for (int i = 1; i <= 30; i++) begin
      if (i == 10) tra_done_i = 1'b1;
      tick();
      tra_done_i = 1'b0;
    end
    check("c1_spur_tra_in_prd", 32'(tra_start_o), 0);
    prd_done_i = 1'b1;
    tick();
    prd_done_i = 1'b0;
    check("c1_pos_start", 32'(tra_start_o), 1);
    check("c1_pos_mode", 32'(tra_mode_o), 1);
    repeat (20) tick();
    check("c1_poswt_mode", 32'(tra_mode_o), 1);
    tra_done_i = 1'b1;
    tick();
    tra_done_i = 1'b0;
    check("c1_done", 32'(done_o), 1);
    check("c1_cyc", 32'(cyc_cnt_o), 73);
    check("c1_sat_cyc", 32'(s_cyc_cnt), 15);
    check("c1_fin_mode", 32'(tra_mode_o), 0);
    check("c1_fin_ctu_x", 32'(tra_ctu_x_o), 5);
    tick();
    check("c1_idle_done", 32'(done_o), 0);
    check("c1_idle_busy", 32'(busy_o), 0);
    check("c1_n_tra", 32'(n_tra - b_tra), 2);
    check("c1_n_prd", 32'(n_prd - b_prd), 1);
    check("c1_n_done", 32'(n_done - b_done), 1);

    // Back-to-back: x=6 pends during PRD_WT, x=7 overflows.
    snap();
    start_i = 1'b1; ctu_x_i = 8'd5;
    tick();
    start_i = 1'b0;
    check("c2_start", 32'(tra_start_o), 1);
    repeat (2) tick();
    tra_done_i = 1'b1;
    tick();
    tra_done_i = 1'b0;
    tick();
    start_i = 1'b1; ctu_x_i = 8'd6;
    tick();
    start_i = 1'b0;
    check("c2_ovf_after_pend", 32'(ovf_o), 0);
    start_i = 1'b1; ctu_x_i = 8'd7;
    tick();
    start_i = 1'b0; ctu_x_i = '0;
    check("c2_ovf_set", 32'(ovf_o), 1);
    prd_done_i = 1'b1;
    tick();
    prd_done_i = 1'b0;
    check("c2_pos_ctu_x", 32'(tra_ctu_x_o), 5);
    tick();
    tra_done_i = 1'b1;
    tick();
    tra_done_i = 1'b0;
    check("c2_fin_done", 32'(done_o), 1);
    check("c2_fin_ctu_x", 32'(tra_ctu_x_o), 5);
    tick();
    check("c2_b2b_start", 32'(tra_start_o), 1);
    check("c2_b2b_busy", 32'(busy_o), 1);
    check("c2_b2b_ctu_x", 32'(tra_ctu_x_o), 6);
    check("c2_b2b_mode", 32'(tra_mode_o), 0);
    tick();
    tra_done_i = 1'b1;
    tick();
    tra_done_i = 1'b0;
    tick();
    prd_done_i = 1'b1;
    tick();
    prd_done_i = 1'b0;
    tick();
    tra_done_i = 1'b1;
    tick();
    tra_done_i = 1'b0;
    check("c2_second_done", 32'(done_o), 1);
    check("c2_second_cyc", 32'(cyc_cnt_o), 6);
    check("c2_second_ctu_x", 32'(tra_ctu_x_o), 6);
    tick();
    check("c2_idle_busy", 32'(busy_o), 0);
    check("c2_ovf_sticky", 32'(ovf_o), 1);
    check("c2_n_done", 32'(n_done - b_done), 2);
    check("c2_n_tra", 32'(n_tra - b_tra), 4);

    // Reset while in PRD_WT, then a fresh CTU x=9.
    start_i = 1'b1; ctu_x_i = 8'd8;
    tick();
    start_i = 1'b0;
    tick();
    tra_done_i = 1'b1;
    tick();
    tra_done_i = 1'b0;
    tick();
    snap();
    #2;
    rstn = 1'b0;
    #1;
    check("r_busy", 32'(busy_o), 0);
    check("r_ovf", 32'(ovf_o), 0);
    check("r_ctu_x", 32'(tra_ctu_x_o), 0);
    check("r_cyc", 32'(cyc_cnt_o), 0);
    check("r_done", 32'(done_o), 0);
    check("r_mode", 32'(tra_mode_o), 0);
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    check("r_idle_busy", 32'(busy_o), 0);
    check("r_no_done", 32'(n_done - b_done), 0);
    start_i = 1'b1; ctu_x_i = 8'd9;
    tick();
    start_i = 1'b0; ctu_x_i = '0;
    check("r9_start", 32'(tra_start_o), 1);
    check("r9_ctu_x", 32'(tra_ctu_x_o), 9);
    tick();
    tra_done_i = 1'b1;
    tick();
    tra_done_i = 1'b0;
    check("r9_prd_start", 32'(prd_start_o), 1);
    tick();
    prd_done_i = 1'b1;
    tick();
    prd_done_i = 1'b0;
    tick();
    tra_done_i = 1'b1;
    tick();
    tra_done_i = 1'b0;
    check("r9_done", 32'(done_o), 1);
    check("r9_cyc", 32'(cyc_cnt_o), 6);
    check("r9_fin_ctu_x", 32'(tra_ctu_x_o), 9);
    tick();

    // 40-cycle CTU: wide counter exact, narrow counter saturated.
    start_i = 1'b1; ctu_x_i = 8'd10;
    tick();
    start_i = 1'b0;
    repeat (13) tick();
    tra_done_i = 1'b1;
    tick();
    tra_done_i = 1'b0;
    repeat (12) tick();
    prd_done_i = 1'b1;
    tick();
    prd_done_i = 1'b0;
    repeat (12) tick();
    tra_done_i = 1'b1;
    tick();
    tra_done_i = 1'b0;
    check("s_done", 32'(done_o), 1);
    check("s_cyc_wide", 32'(cyc_cnt_o), 40);
    check("s_cyc_sat", 32'(s_cyc_cnt), 15);
    tick();
    check("s_idle_busy", 32'(busy_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/posi_ctrl.md
POSI_CTRL -- requirements
Module: posi_ctrl

Interface
REQ-001 Parameter MODE_PRE, default 0, mode code driven on tra_mode_o for the pre-prediction transfer pass.
REQ-002 Parameter MODE_POS, default 1, mode code driven on tra_mode_o for the post-prediction transfer pass.
REQ-003 Parameter CNT_WD, default 16, width of the per-CTU cycle counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 start_i  input  1  one-cycle CTU start request.
REQ-007 ctu_x_i  input  `PIC_X_WIDTH  CTU x index, sampled together with start_i.
REQ-008 tra_start_o  output  1  one-cycle start pulse to the transfer block.
REQ-009 tra_mode_o  output  1  transfer mode (MODE_PRE/MODE_POS).
REQ-010 tra_ctu_x_o  output  `PIC_X_WIDTH  CTU x index for the transfer block.
REQ-011 tra_done_i  input  1  one-cycle transfer completion pulse.
REQ-012 prd_start_o  output  1  one-cycle start pulse to the intra prediction core.
REQ-013 prd_done_i  input  1  one-cycle prediction completion pulse.
REQ-014 busy_o  output  1  high whenever the FSM is not IDLE.
REQ-015 done_o  output  1  one-cycle CTU completion pulse.
REQ-016 cyc_cnt_o  output  CNT_WD  cycles used by the last completed CTU.
REQ-017 ovf_o  output  1  sticky flag: a start request was dropped.

Function
REQ-018 States: IDLE, PRE_ISS, PRE_WT, PRD_ISS, PRD_WT, POS_ISS, POS_WT, FIN; all outputs registered or decoded from state only (Moore).
REQ-019 IDLE -> PRE_ISS when start_i=1; ctu_x_i latched into tra_ctu_x_o the same edge.
REQ-020 PRE_ISS -> PRE_WT unconditionally; tra_start_o=1, tra_mode_o=MODE_PRE during PRE_ISS.
REQ-021 PRE_WT -> PRD_ISS on tra_done_i=1, else hold.
REQ-022 PRD_ISS -> PRD_WT unconditionally; prd_start_o=1 during PRD_ISS.
REQ-023 PRD_WT -> POS_ISS on prd_done_i=1, else hold.
REQ-024 POS_ISS -> POS_WT unconditionally; tra_start_o=1, tra_mode_o=MODE_POS during POS_ISS.
REQ-025 POS_WT -> FIN on tra_done_i=1, else hold.
REQ-026 FIN: done_o=1 for exactly this cycle; FIN -> PRE_ISS if pending entry valid (pending ctu_x moved to tra_ctu_x_o, pending cleared), else -> IDLE.
REQ-027 tra_mode_o equals MODE_POS in POS_ISS/POS_WT, MODE_PRE in all other states.
REQ-028 tra_ctu_x_o stable from PRE_ISS through FIN; changes only on the edge entering PRE_ISS.
REQ-029 tra_done_i honoured only in PRE_WT/POS_WT, prd_done_i only in PRD_WT; ignored in all other states.
REQ-030 start_i while not IDLE: stored in one-deep pending register (valid + ctu_x) if empty; if already full, request dropped and ovf_o set to 1 until reset.
REQ-031 start_i in FIN with pending empty: treated as pending write, consumed same edge (FIN -> PRE_ISS with that ctu_x).
REQ-032 Latency: start_i at edge T -> tra_start_o high in cycle T+1; tra_done_i at T -> prd_start_o high T+1; prd_done_i at T -> tra_start_o high T+1; final tra_done_i at T -> done_o high T+1.
REQ-033 Cycle counter cleared on entering PRE_ISS, increments each cycle in PRE_ISS..POS_WT, saturates at 2^CNT_WD-1; value copied to cyc_cnt_o on entering FIN.
REQ-034 busy_o=1 in every state except IDLE.

Reset
REQ-035 rstn=0 forces, asynchronously: state IDLE, pending cleared, counter 0, tra_start_o/prd_start_o/done_o/busy_o/ovf_o=0, tra_mode_o=MODE_PRE, tra_ctu_x_o=0, cyc_cnt_o=0.
REQ-036 Reset mid-operation abandons the CTU without issuing done_o; first start_i after release restarts from PRE_ISS.

Verification
REQ-037 Single CTU: start_i, ctu_x_i=5; tra_done 20 cycles after PRE start, prd_done 30 after, tra_done 20 after -> pulses in order PRE/PRD/POS, tra_ctu_x_o=5 throughout, done_o once, cyc_cnt_o=73.
REQ-038 Back-to-back: second start_i (ctu_x_i=6) during PRD_WT -> pending held; FIN -> PRE_ISS next cycle with tra_ctu_x_o=6, no IDLE cycle, ovf_o=0.
REQ-039 Overflow: third start_i (ctu_x_i=7) while pending full -> dropped, ovf_o=1 and stays 1; only CTUs 5 and 6 complete.
REQ-040 Spurious done: tra_done_i in PRD_WT and prd_done_i in PRE_WT -> no state change, no extra start pulses.
REQ-041 Reset in PRD_WT -> all outputs reset values immediately, no done_o; new start_i with ctu_x_i=9 -> normal sequence.
REQ-042 Saturation: CNT_WD=4, CTU lasting 40 cycles -> cyc_cnt_o=15.
